// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - processor data-memory handshake signals
interface dmem_responder_if;
   logic [31:0] DAD;
   logic        MREQ;
   logic        WRITE;
   logic [1:0]  SIZE;
   logic        ACKD_n;
   logic        err;

   modport master (output DAD, output MREQ, output WRITE, output SIZE,
                   input ACKD_n, input err);
   modport slave  (input DAD, input MREQ, input WRITE, input SIZE,
                   output ACKD_n, output err);
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder with byte/half/word access
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   dmem_responder_if.slave   bus,
   inout  wire  [31:0]       DDT
);

   localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic [AW-1:0] idx_q;
   logic [1:0]    lane_q;
   logic [1:0]    size_q;
   logic          write_q;
   logic          illegal_q;
   logic [31:0]   wdata_q;
   logic          err_q;

   logic [31:0]   mem [DEPTH_WORDS];

   // Request decode, evaluated on the live bus when a request is captured.
   // The offset is an unsigned difference so addresses below the base wrap
   // to huge values and fall out of range naturally.
   logic [31:0]   off;
   logic          misaligned;
   logic          out_of_range;
   logic          req_illegal;

   assign off          = bus.DAD - BASE_ADDR;
   assign out_of_range = ({1'b0, off} >= LIMIT);

   // Alignment rule depends on access size.
   always_comb begin
      misaligned = 1'b0;
      case (bus.SIZE)
         2'b01:   misaligned = bus.DAD[0];
         2'b10:   misaligned = |bus.DAD[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign req_illegal = (bus.SIZE == 2'b11) | misaligned | out_of_range;

   // Handshake FSM plus request capture; err is sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.MREQ) begin
                  idx_q     <= off[AW+1:2];
                  lane_q    <= bus.DAD[1:0];
                  size_q    <= bus.SIZE;
                  write_q   <= bus.WRITE;
                  wdata_q   <= DDT;
                  illegal_q <= req_illegal;
                  err_q     <= err_q | req_illegal;
                  cnt_q     <= 4'(WAIT_CYCLES);
                  state_q   <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
               end
            end
            S_WAIT: begin
               if (!bus.MREQ) begin
                  cnt_q   <= 4'd0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     state_q <= S_ACK;
                  end
               end
            end
            S_ACK: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Byte enables and lane-replicated write data from the captured request.
   logic [3:0]  be;
   logic [31:0] wlanes;

   always_comb begin
      be     = 4'b0000;
      wlanes = wdata_q;
      case (size_q)
         2'b00: begin
            be     = 4'b0001 << lane_q;
            wlanes = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be     = 4'b0011 << lane_q;
            wlanes = {2{wdata_q[15:0]}};
         end
         2'b10: begin
            be     = 4'b1111;
            wlanes = wdata_q;
         end
         default: begin
            be     = 4'b0000;
            wlanes = wdata_q;
         end
      endcase
   end

   // Write commits on the edge that closes ACK, unless reset is asserted there.
   always_ff @(posedge clk) begin
      if (!rst && state_q == S_ACK && write_q && !illegal_q) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[idx_q][8*b +: 8] <= wlanes[8*b +: 8];
            end
         end
      end
   end

   // Read data: addressed lane(s) right-justified and zero-extended.
   logic [31:0] rword;
   logic [31:0] rshift;
   logic [31:0] rdata;

   assign rword  = mem[idx_q];
   assign rshift = rword >> {lane_q, 3'b000};

   always_comb begin
      rdata = 32'h0;
      if (!illegal_q) begin
         case (size_q)
            2'b00:   rdata = {24'h0, rshift[7:0]};
            2'b01:   rdata = {16'h0, rshift[15:0]};
            2'b10:   rdata = rword;
            default: rdata = 32'h0;
         endcase
      end
   end

   assign DDT = (state_q == S_ACK && !write_q) ? rdata : 32'bz;

   // Acknowledge is low only in ACK, or when idle with no request pending.
   always_comb begin
      bus.ACKD_n = 1'b1;
      case (state_q)
         S_IDLE:  bus.ACKD_n = bus.MREQ;
         S_WAIT:  bus.ACKD_n = 1'b1;
         S_ACK:   bus.ACKD_n = 1'b0;
         default: bus.ACKD_n = 1'b1;
      endcase
   end

   assign bus.err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Shared stimulus; MREQ and DDT are routed only to the selected instance.
   logic [31:0] dad;
   logic [31:0] tb_wdata;
   logic        mreq;
   logic        wr_in;
   logic        tb_oe;
   logic [1:0]  size_in;
   int          sel;

   // Instance 0: no wait states, nonzero base. 1: one wait. 2: three waits.
   int          wc   [3] = '{0, 1, 3};
   logic [31:0] base [3] = '{32'h0000_1000, 32'h0, 32'h0};

   dmem_responder_if bus0 ();
   dmem_responder_if bus1 ();
   dmem_responder_if bus2 ();
   wire [31:0] ddt0;
   wire [31:0] ddt1;
   wire [31:0] ddt2;

   assign bus0.DAD = dad;  assign bus0.WRITE = wr_in;  assign bus0.SIZE = size_in;
   assign bus1.DAD = dad;  assign bus1.WRITE = wr_in;  assign bus1.SIZE = size_in;
   assign bus2.DAD = dad;  assign bus2.WRITE = wr_in;  assign bus2.SIZE = size_in;
   assign bus0.MREQ = mreq && (sel == 0);
   assign bus1.MREQ = mreq && (sel == 1);
   assign bus2.MREQ = mreq && (sel == 2);
   assign ddt0 = (tb_oe && sel == 0) ? tb_wdata : 32'bz;
   assign ddt1 = (tb_oe && sel == 1) ? tb_wdata : 32'bz;
   assign ddt2 = (tb_oe && sel == 2) ? tb_wdata : 32'bz;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000))
      u_w0 (.clk(clk), .rst(rst), .bus(bus0), .DDT(ddt0));
   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(32'h0))
      u_w1 (.clk(clk), .rst(rst), .bus(bus1), .DDT(ddt1));
   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(32'h0))
      u_w3 (.clk(clk), .rst(rst), .bus(bus2), .DDT(ddt2));

   int checks = 0;
   int errors = 0;

   // Reference model: flat byte array per instance, little-endian.
   bit [7:0] mb   [3][DEPTH*4];
   bit       merr [3];

   function automatic logic get_ack(int s);
      case (s)
         0:       return bus0.ACKD_n;
         1:       return bus1.ACKD_n;
         default: return bus2.ACKD_n;
      endcase
   endfunction

   function automatic logic get_err(int s);
      case (s)
         0:       return bus0.err;
         1:       return bus1.err;
         default: return bus2.err;
      endcase
   endfunction

   function automatic logic [31:0] get_ddt(int s);
      case (s)
         0:       return ddt0;
         1:       return ddt1;
         default: return ddt2;
      endcase
   endfunction

   function automatic bit legal(int s, logic [1:0] sz, logic [31:0] a);
      int unsigned nbytes;
      logic [31:0] off;
      if (sz == 2'b11) return 1'b0;
      nbytes = 1 << sz;
      if ((a % nbytes) != 0) return 1'b0;
      off = a - base[s];
      return off < DEPTH * 4;
   endfunction

   function automatic logic [31:0] model_read(int s, logic [1:0] sz, logic [31:0] a);
      logic [31:0] off;
      logic [31:0] v;
      off = a - base[s];
      v   = 32'h0;
      for (int i = 0; i < (1 << sz); i++) begin
         v = v | (32'(mb[s][off + i]) << (8 * i));
      end
      return v;
   endfunction

   task automatic model_write(int s, logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
      logic [31:0] off;
      off = a - base[s];
      for (int i = 0; i < (1 << sz); i++) begin
         mb[s][off + i] = wd[8*i +: 8];
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // One full access. Request inputs are scrambled after capture to show they
   // no longer matter. Returns the value seen on DDT in the ACK cycle of a read.
   task automatic do_acc(input int s, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit keep, output logic [31:0] rd);
      bit          lg;
      logic [31:0] exp_rd;
      rd     = 32'h0;
      lg     = legal(s, sz, a);
      exp_rd = lg ? model_read(s, sz, a) : 32'h0;
      sel = s; dad = a; wr_in = wr; size_in = sz; tb_wdata = wd; tb_oe = wr; mreq = 1'b1;
      for (int c = 0; c <= wc[s] + 1; c++) begin
         @(negedge clk);
         chk("ackd_n", {31'h0, get_ack(s)}, (c == wc[s] + 1) ? 32'h0 : 32'h1);
         if (c == wc[s] + 1 && !wr) begin
            rd = get_ddt(s);
            chk("read_data", rd, exp_rd);
         end
         @(posedge clk); #1;
         if (c == 0) begin
            dad = $urandom; wr_in = 1'($urandom); size_in = 2'($urandom);
            if (wr) tb_wdata = $urandom;
         end
      end
      if (!lg) merr[s] = 1'b1;
      if (wr && lg) model_write(s, sz, a, wd);
      chk("err", {31'h0, get_err(s)}, {31'h0, merr[s]});
      if (!keep) begin
         mreq = 1'b0; tb_oe = 1'b0;
      end
   endtask

   // Word write abandoned in cycle 'at' by reset or by dropping MREQ; the
   // following read must see the old contents.
   task automatic abort_acc(input int s, input logic [31:0] a, input logic [31:0] wd,
                            input int at, input bit by_rst);
      logic [31:0] rd;
      sel = s; dad = a; wr_in = 1'b1; size_in = 2'b10; tb_wdata = wd; tb_oe = 1'b1; mreq = 1'b1;
      for (int c = 0; c < at; c++) begin
         @(negedge clk);
         chk("abort_ackd_n", {31'h0, get_ack(s)}, 32'h1);
         @(posedge clk); #1;
      end
      if (by_rst) rst = 1'b1;
      else begin
         mreq = 1'b0; tb_oe = 1'b0;
      end
      @(negedge clk);
      chk("abort_cycle_ackd_n", {31'h0, get_ack(s)}, (by_rst && at == wc[s] + 1) ? 32'h0 : 32'h1);
      @(posedge clk); #1;
      rst = 1'b0; mreq = 1'b0; tb_oe = 1'b0;
      if (by_rst) begin
         merr = '{1'b0, 1'b0, 1'b0};
         @(negedge clk);
         chk("post_rst_ackd_n", {31'h0, get_ack(s)}, 32'h0);
         chk("post_rst_err", {31'h0, get_err(s)}, 32'h0);
         @(posedge clk); #1;
      end
      do_acc(s, 1'b0, 2'b10, a, 32'h0, 1'b0, rd);
   endtask

   typedef struct {
      int          s;
      bit          wr;
      logic [1:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      bit          exp_err;
   } vec_t;

   vec_t tbl [15];

   initial begin
      logic [31:0] rd;
      tbl[0]  = '{1, 1'b1, 2'b10, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
      tbl[1]  = '{1, 1'b0, 2'b10, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
      tbl[2]  = '{1, 1'b1, 2'b10, 32'h10,   32'h0,        32'h0,        1'b0};
      tbl[3]  = '{1, 1'b1, 2'b00, 32'h13,   32'h123456A5, 32'h0,        1'b0};
      tbl[4]  = '{1, 1'b0, 2'b10, 32'h10,   32'h0,        32'hA5000000, 1'b0};
      tbl[5]  = '{1, 1'b0, 2'b01, 32'h12,   32'h0,        32'h0000A500, 1'b0};
      tbl[6]  = '{1, 1'b0, 2'b01, 32'h11,   32'h0,        32'h0,        1'b1};
      tbl[7]  = '{1, 1'b0, 2'b10, 32'h10,   32'h0,        32'hA5000000, 1'b1};
      tbl[8]  = '{1, 1'b1, 2'b01, 32'h16,   32'h7777BEEF, 32'h0,        1'b1};
      tbl[9]  = '{1, 1'b0, 2'b00, 32'h17,   32'h0,        32'h000000BE, 1'b1};
      tbl[10] = '{0, 1'b1, 2'b10, 32'h10FC, 32'hCAFEF00D, 32'h0,        1'b0};
      tbl[11] = '{0, 1'b0, 2'b10, 32'h10FC, 32'h0,        32'hCAFEF00D, 1'b0};
      tbl[12] = '{0, 1'b0, 2'b10, 32'h1100, 32'h0,        32'h0,        1'b1};
      tbl[13] = '{0, 1'b0, 2'b10, 32'h0FFC, 32'h0,        32'h0,        1'b1};
      tbl[14] = '{2, 1'b1, 2'b11, 32'h30,   32'h12345678, 32'h0,        1'b1};

      rst = 1'b1; mreq = 1'b0; tb_oe = 1'b0; sel = 0;
      dad = 32'h0; wr_in = 1'b0; size_in = 2'b00; tb_wdata = 32'h0;
      merr = '{1'b0, 1'b0, 1'b0};
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         chk("reset_ackd_n", {31'h0, get_ack(s)}, 32'h0);
         chk("reset_err", {31'h0, get_err(s)}, 32'h0);
      end
      @(posedge clk); #1;

      // Fill every word so the model knows the whole array.
      for (int s = 0; s < 3; s++) begin
         for (int w = 0; w < DEPTH; w++) begin
            do_acc(s, 1'b1, 2'b10, base[s] + 32'(4 * w), $urandom, 1'b0, rd);
         end
      end

      for (int i = 0; i < 15; i++) begin
         do_acc(tbl[i].s, tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].wd, 1'b0, rd);
         if (!tbl[i].wr) chk("tbl_rdata", rd, tbl[i].exp_rd);
         chk("tbl_err", {31'h0, get_err(tbl[i].s)}, {31'h0, tbl[i].exp_err});
      end

      // Back-to-back reads with no wait states: ACKD_n 1,0,1,0.
      do_acc(0, 1'b0, 2'b10, 32'h1000, 32'h0, 1'b1, rd);
      do_acc(0, 1'b0, 2'b10, 32'h1004, 32'h0, 1'b0, rd);

      abort_acc(2, 32'h20, 32'h11223344, 2, 1'b1);
      abort_acc(1, 32'h14, 32'h55AA55AA, 2, 1'b1);
      abort_acc(2, 32'h24, 32'h99887766, 2, 1'b0);

      for (int n = 0; n < 300; n++) begin
         int          s;
         int          r;
         logic [1:0]  sz;
         logic [31:0] off;
         s  = $urandom_range(0, 2);
         r  = $urandom_range(0, 9);
         sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         off = 32'($urandom_range(0, DEPTH * 4 - 1));
         if ($urandom_range(0, 7) != 0 && sz != 2'b11) off = off & ~(32'(1 << sz) - 32'h1);
         if ($urandom_range(0, 15) == 0) off = 32'(DEPTH * 4 + $urandom_range(0, 64));
         if ($urandom_range(0, 31) == 0) off = 32'hFFFF_FFFC;
         do_acc(s, 1'($urandom_range(0, 1)), sz, base[s] + off, $urandom,
                ($urandom_range(0, 3) == 0), rd);
      end
      mreq = 1'b0; tb_oe = 1'b0;
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
